wb_pipelined_slave_mem: RTL and testbench

//  Wishbone B4 pipelined responder: the slave end that simulation masters drive.

---
 rtl/wb_pipelined_slave_mem_if.sv | 28 ++
 rtl/wb_pipelined_slave_mem.sv | 133 +++++++++++++
 tb/tb_wb_pipelined_slave_mem.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_pipelined_slave_mem_if.sv
// Wishbone B4 pipelined bus bundle for wb_pipelined_slave_mem.
// Signal suffixes are from the slave's point of view.
interface wb_pipelined_slave_mem_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            cyc_i;
  logic            stb_i;
  logic            we_i;
  logic [DW/8-1:0] sel_i;
  logic [AW-1:0]   adr_i;
  logic [DW-1:0]   dat_i;
  logic            ack_o;
  logic            err_o;
  logic            rty_o;
  logic            stall_o;
  logic [DW-1:0]   dat_o;

  modport master (
    output cyc_i, stb_i, we_i, sel_i, adr_i, dat_i,
    input  ack_o, err_o, rty_o, stall_o, dat_o
  );

  modport slave (
    input  cyc_i, stb_i, we_i, sel_i, adr_i, dat_i,
    output ack_o, err_o, rty_o, stall_o, dat_o
  );
endinterface

// File: rtl/wb_pipelined_slave_mem.sv
// Wishbone B4 pipelined memory slave: fixed ack latency, bounded outstanding requests,
// err on out-of-range addresses. Define WB_SLAVE_RANDOM_STALL_EN for LFSR-driven stall injection.
module wb_pipelined_slave_mem #(
  parameter int g_addr_width      = 32,
  parameter int g_data_width      = 32,
  parameter int g_mem_words       = 1024,
  parameter int g_ack_latency     = 2,
  parameter int g_max_outstanding = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  wb_pipelined_slave_mem_if.slave wb
);
  localparam int IDX_W = $clog2(g_mem_words);
  localparam int SEL_W = g_data_width / 8;
  localparam int CNT_W = $clog2(g_max_outstanding + 1);
  localparam int LAT   = g_ack_latency;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(g_max_outstanding);

  logic [g_data_width-1:0] mem [g_mem_words];
  logic [g_data_width-1:0] rd_data_q;
  logic [g_data_width-1:0] pipe_dat;
  logic [LAT-1:0]          vld_q, vld_d;
  logic [LAT-1:0]          err_q, err_d;
  logic [LAT-1:0]          is_rd_q, is_rd_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx;
  logic                    oor;
  logic                    accept;
  logic                    resp;
  logic                    resp_ack;
  logic                    cnt_stall;
  logic                    rnd_stall;
  logic                    stall;
  logic                    unused_adr;

  assign idx        = wb.adr_i[IDX_W+1:2];
  assign oor        = |(wb.adr_i >> (IDX_W + 2));
  assign unused_adr = ^wb.adr_i[1:0];

  // A response pending at the pipe tail is suppressed as soon as the master drops cyc.
  assign resp     = vld_q[LAT-1] & wb.cyc_i;
  assign resp_ack = resp & ~err_q[LAT-1];

  assign cnt_stall = (cnt_q == CNT_MAX) & ~resp;
  assign stall     = cnt_stall | rnd_stall;
  assign accept    = wb.cyc_i & wb.stb_i & ~stall;

  assign wb.ack_o   = resp_ack;
  assign wb.err_o   = resp & err_q[LAT-1];
  assign wb.rty_o   = 1'b0;
  assign wb.stall_o = stall;
  assign wb.dat_o   = (resp_ack & is_rd_q[LAT-1]) ? pipe_dat : '0;

`ifdef WB_SLAVE_RANDOM_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  // x^16+x^14+x^13+x^11+1 in right-shifting Fibonacci form.
  always_comb begin
    lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) lfsr_q <= 16'hACE1;
    else          lfsr_q <= lfsr_d;
  end

  assign rnd_stall = (lfsr_q[1:0] == 2'b00);
`else
  assign rnd_stall = 1'b0;
`endif

  always_comb begin
    vld_d   = '0;
    err_d   = '0;
    is_rd_d = '0;
    cnt_d   = '0;
    if (wb.cyc_i) begin
      vld_d[0]   = accept;
      err_d[0]   = oor;
      is_rd_d[0] = ~wb.we_i;
      for (int i = 1; i < LAT; i++) begin
        vld_d[i]   = vld_q[i-1];
        err_d[i]   = err_q[i-1];
        is_rd_d[i] = is_rd_q[i-1];
      end
      cnt_d = cnt_q + CNT_W'(accept) - CNT_W'(resp);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vld_q   <= '0;
      err_q   <= '0;
      is_rd_q <= '0;
      cnt_q   <= '0;
    end else begin
      vld_q   <= vld_d;
      err_q   <= err_d;
      is_rd_q <= is_rd_d;
      cnt_q   <= cnt_d;
    end
  end

  // Write and read both happen at the acceptance edge; only one request per edge.
  always_ff @(posedge clk_i) begin
    if (accept && !oor) begin
      if (wb.we_i) begin
        for (int b = 0; b < SEL_W; b++) begin
          if (wb.sel_i[b]) mem[idx][b*8 +: 8] <= wb.dat_i[b*8 +: 8];
        end
      end else begin
        rd_data_q <= mem[idx];
      end
    end
  end

  generate
    if (LAT == 1) begin : g_lat1
      assign pipe_dat = rd_data_q;
    end else begin : g_latn
      logic [g_data_width-1:0] dly_q [LAT-1];

      // Data shifts in lockstep with the valid bits; stage 0 is rd_data_q itself.
      always_ff @(posedge clk_i) begin
        dly_q[0] <= rd_data_q;
        for (int i = 1; i < LAT - 1; i++) dly_q[i] <= dly_q[i-1];
      end

      assign pipe_dat = dly_q[LAT-2];
    end
  endgenerate
endmodule

// File: tb/tb_wb_pipelined_slave_mem.sv
// Self-checking bench for wb_pipelined_slave_mem: transaction-level scoreboard model
// checked every cycle, plus hand-computed literal expectations for directed scenarios.
`timescale 1ns/1ps
module tb_wb_pipelined_slave_mem;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int WORDS = 1024;
  localparam int L     = 3;
  localparam int MAXO  = 2;
  localparam int LOGN  = 16384;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_pipelined_slave_mem_if #(.AW(AW), .DW(DW)) bus ();

  wb_pipelined_slave_mem #(
    .g_addr_width     (AW),
    .g_data_width     (DW),
    .g_mem_words      (WORDS),
    .g_ack_latency    (L),
    .g_max_outstanding(MAXO)
  ) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .wb     (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_n = 0;

  typedef struct {
    int          due;
    bit          err;
    bit          rd;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  logic [31:0] mem_m [WORDS];
  logic [15:0] lfsr_m;
  int          kind_log [LOGN];
  logic [31:0] dat_log [LOGN];
  bit          stall_log [LOGN];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc_n);
    end
  endtask

  // Response due this cycle: oldest pending request whose deadline is now, cyc still high.
  function automatic bit m_resp();
    return bus.cyc_i && (q.size() > 0) && (q[0].due == cyc_n);
  endfunction

  function automatic bit m_stall();
    bit s;
    s = (q.size() == MAXO) && !m_resp();
`ifdef WB_SLAVE_RANDOM_STALL_EN
    s = s | (lfsr_m[1:0] == 2'b00);
`endif
    return s;
  endfunction

  always @(posedge clk) cyc_n <= cyc_n + 1;

  always @(posedge clk or negedge rst_n) begin
    bit   r;
    bit   acc;
    bit   oor;
    int   idx;
    ent_t e;
    if (!rst_n) begin
      q.delete();
      lfsr_m = 16'hACE1;
    end else begin
      r   = m_resp();
      acc = bus.cyc_i && bus.stb_i && !m_stall();
      if (!bus.cyc_i) begin
        q.delete();
      end else begin
        if (r) void'(q.pop_front());
        if (acc) begin
          oor    = (bus.adr_i >= 32'(WORDS * 4));
          idx    = int'((bus.adr_i / 4) % WORDS);
          e.due  = cyc_n + L;
          e.err  = oor;
          e.rd   = !bus.we_i;
          e.data = 32'h0;
          if (!oor) begin
            if (bus.we_i) begin
              for (int b = 0; b < 4; b++)
                if (bus.sel_i[b]) mem_m[idx][b*8 +: 8] = bus.dat_i[b*8 +: 8];
            end else begin
              e.data = mem_m[idx];
            end
          end
          q.push_back(e);
        end
      end
`ifdef WB_SLAVE_RANDOM_STALL_EN
      lfsr_m = {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
`endif
    end
  end

  always @(negedge clk) begin
    bit          r;
    bit          e_ack;
    bit          e_err;
    logic [31:0] e_dat;
    r     = m_resp();
    e_ack = 1'b0;
    e_err = 1'b0;
    e_dat = 32'h0;
    if (r) begin
      e_ack = !q[0].err;
      e_err = q[0].err;
      if (e_ack && q[0].rd) e_dat = q[0].data;
    end
    chk("ack_o", 32'(bus.ack_o), 32'(e_ack));
    chk("err_o", 32'(bus.err_o), 32'(e_err));
    chk("stall_o", 32'(bus.stall_o), 32'(m_stall()));
    chk("rty_o", 32'(bus.rty_o), 32'h0);
    chk("dat_o", bus.dat_o, e_dat);
    if (cyc_n >= 0 && cyc_n < LOGN) begin
      kind_log[cyc_n]  = bus.ack_o ? 1 : (bus.err_o ? 2 : 0);
      dat_log[cyc_n]   = bus.dat_o;
      stall_log[cyc_n] = bus.stall_o;
    end
  end

  function automatic int kind_at(input int c);
    if (c < 0 || c >= LOGN) return 9;
    return kind_log[c];
  endfunction

  function automatic logic [31:0] dat_at(input int c);
    if (c < 0 || c >= LOGN) return 32'hFFFF_FFFF;
    return dat_log[c];
  endfunction

  // Present one request and hold it until the slave accepts it; returns the acceptance edge.
  task automatic req(input bit we, input logic [31:0] adr, input logic [3:0] sel,
                     input logic [31:0] dat, output int acc);
    bus.cyc_i = 1'b1;
    bus.stb_i = 1'b1;
    bus.we_i  = we;
    bus.adr_i = adr;
    bus.sel_i = sel;
    bus.dat_i = dat;
    acc = -1;
    for (int t = 0; t < 100 && acc < 0; t++) begin
      @(negedge clk);
      if (!bus.stall_o) begin
        @(posedge clk);
        #1;
        acc = cyc_n;
      end
    end
    if (acc < 0) chk("accept_timeout", 32'h1, 32'h0);
    $display("req we=%0d adr=%h sel=%h dat=%h accepted at edge %0d", we, adr, sel, dat, acc);
  endtask

  task automatic idle(input int n);
    bus.stb_i = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic lit_resp(input string nm, input int acc, input int kind, input logic [31:0] dat);
    chk({nm, "_kind"}, 32'(kind_at(acc + L - 1)), 32'(kind));
    if (kind == 1) chk({nm, "_dat"}, dat_at(acc + L - 1), dat);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1, a2, a3;
    int acc6 [6];
    int k;
    int nrand;
    logic [31:0] ra;

    bus.cyc_i = 1'b0;
    bus.stb_i = 1'b0;
    bus.we_i  = 1'b0;
    bus.adr_i = '0;
    bus.sel_i = '0;
    bus.dat_i = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", 32'(bus.ack_o), 32'h0);
    chk("rst_err", 32'(bus.err_o), 32'h0);
    chk("rst_stall", 32'(bus.stall_o), 32'h0);
    chk("rst_dat", bus.dat_o, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: full write then read back
    req(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, a0);
    req(1'b0, 32'h10, 4'hF, 32'h0, a1);
    idle(L + 3);
    lit_resp("t1_wr", a0, 1, 32'h0);
    lit_resp("t1_rd", a1, 1, 32'hDEADBEEF);

    // 2: byte-lane merge
    req(1'b1, 32'h20, 4'hF, 32'h11223344, a0);
    req(1'b1, 32'h20, 4'b0010, 32'h0000AA00, a1);
    req(1'b0, 32'h20, 4'hF, 32'h0, a2);
    idle(L + 3);
    lit_resp("t2_rd", a2, 1, 32'h1122AA44);

    // 3: six reads with stb held; outstanding limit forces stalls
    for (int i = 0; i < 6; i++) req(1'b0, (i % 2) ? 32'h20 : 32'h10, 4'hF, 32'h0, acc6[i]);
    idle(L + 4);
    for (int i = 0; i < 6; i++)
      lit_resp("t3_rd", acc6[i], 1, (i % 2) ? 32'h1122AA44 : 32'hDEADBEEF);
`ifndef WB_SLAVE_RANDOM_STALL_EN
    chk("t3_stall_full", 32'(stall_log[acc6[1]]), 32'h1);
    chk("t3_stall_at_ack", 32'(stall_log[acc6[0] + L - 1]), 32'h0);
    chk("t3_acc_spacing2", 32'(acc6[2] - acc6[0]), 32'd3);
    chk("t3_acc_spacing5", 32'(acc6[5] - acc6[0]), 32'd7);
`endif

    // 4: out-of-range accesses produce err and leave aliased word untouched
    req(1'b1, 32'h0, 4'hF, 32'h0BADF00D, a0);
    req(1'b1, 32'h1000, 4'hF, 32'hAAAA5555, a1);
    req(1'b0, 32'h1000, 4'hF, 32'h0, a2);
    req(1'b0, 32'h0, 4'hF, 32'h0, a3);
    idle(L + 3);
    lit_resp("t4_oor_wr", a1, 2, 32'h0);
    lit_resp("t4_oor_rd", a2, 2, 32'h0);
    lit_resp("t4_alias_rd", a3, 1, 32'h0BADF00D);

    // 5: cycle abort flushes responses but keeps the accepted write
    req(1'b1, 32'h30, 4'hF, 32'h5A5A5A5A, a0);
    req(1'b0, 32'h10, 4'hF, 32'h0, a1);
    bus.cyc_i = 1'b0;
    bus.stb_i = 1'b0;
    repeat (L + 3) @(posedge clk);
    #1;
`ifndef WB_SLAVE_RANDOM_STALL_EN
    lit_resp("t5_wr_flushed", a0, 0, 32'h0);
`endif
    lit_resp("t5_rd_flushed", a1, 0, 32'h0);
    chk("t5_stall_after", 32'(stall_log[a1 + 1]), 32'h0);
    req(1'b0, 32'h30, 4'hF, 32'h0, a2);
    idle(L + 3);
    lit_resp("t5_new_rd", a2, 1, 32'h5A5A5A5A);

    // 6: async reset while an ack is on the bus
    req(1'b0, 32'h10, 4'hF, 32'h0, a0);
    req(1'b0, 32'h10, 4'hF, 32'h0, a1);
    req(1'b0, 32'h10, 4'hF, 32'h0, a2);
    #1;
`ifndef WB_SLAVE_RANDOM_STALL_EN
    chk("t6_ack_before_rst", 32'(bus.ack_o), 32'h1);
`endif
    rst_n = 1'b0;
    #1;
    chk("t6_rst_ack", 32'(bus.ack_o), 32'h0);
    chk("t6_rst_err", 32'(bus.err_o), 32'h0);
    chk("t6_rst_stall", 32'(bus.stall_o), 32'h0);
    chk("t6_rst_dat", bus.dat_o, 32'h0);
    bus.cyc_i = 1'b0;
    bus.stb_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.cyc_i = 1'b1;
    idle(5);
    req(1'b0, 32'h20, 4'hF, 32'h0, a3);
    idle(L + 3);
    lit_resp("t6_after_rst", a3, 1, 32'h1122AA44);

    // Random traffic over a pre-initialised pool of words, checked by the scoreboard.
    for (int i = 0; i < 8; i++) req(1'b1, 32'h40 + 32'(4 * i), 4'hF, $urandom, a0);
`ifdef WB_SLAVE_RANDOM_STALL_EN
    nrand = 1000;
`else
    nrand = 200;
`endif
    for (int i = 0; i < nrand; i++) begin
      k  = int'($urandom_range(0, 7));
      ra = 32'h40 + 32'(4 * k) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) ra = ra | 32'h0001_0000;
      req(1'($urandom_range(0, 1)), ra, 4'($urandom_range(0, 15)), $urandom, a0);
      if ($urandom_range(0, 3) == 0) idle(1);
      if ($urandom_range(0, 29) == 0) begin
        bus.cyc_i = 1'b0;
        bus.stb_i = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    idle(L + 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
